// File: rtl/axa_arb_pkg.sv
// Shared definitions for the two-requester 2x2 multiplier arbiter:
// FSM encoding, bus widths, watchdog limit and the round-robin pick.
package axa_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  localparam int AB_W           = 256;
  localparam int C_W            = 128;
  localparam int WORD_W         = 32;
  localparam int TIMEOUT_CYCLES = 256;

  // A lone requester wins outright; a tie is broken by the pointer.
  function automatic logic arb_pick(input logic i_r0, input logic i_r1, input logic i_ptr);
    return (i_r0 && i_r1) ? i_ptr : i_r1;
  endfunction

endpackage

// File: rtl/axa_arb_watchdog.sv
// Stall watchdog for the arbiter: counts consecutive cycles spent in ISSUE or
// WAIT and flags the edge on which the limit is reached (AXA_ARB_TIMEOUT_EN builds only).
module axa_arb_watchdog
  import axa_arb_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  state_t i_state,
  output logic   o_fire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_cnt;
  state_t           r_prev;
  logic             w_active;
  logic [CNT_W-1:0] w_cnt;

  assign w_active = (i_state == ST_ISSUE) || (i_state == ST_WAIT);
  // A fresh state restarts the count, so ISSUE and WAIT are timed separately.
  assign w_cnt    = (i_state != r_prev) ? '0 : r_cnt;
  assign o_fire   = w_active && (w_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_prev <= ST_IDLE;
    end else begin
      r_prev <= i_state;
      r_cnt  <= w_active ? (w_cnt + CNT_W'(1)) : '0;
    end
  end

endmodule

// File: rtl/axa_mult_arbiter.sv
// Round-robin arbiter sharing one 2x2 float multiplier between two requesters.
// Optional stall watchdog enabled by defining AXA_ARB_TIMEOUT_EN.
module axa_mult_arbiter
  import axa_arb_pkg::*;
(
  input  logic            input_Clk,
  input  logic            input_Reset,
  input  logic            input_R0_Stable,
  input  logic            input_R1_Stable,
  input  logic [AB_W-1:0] input_R0_AB,
  input  logic [AB_W-1:0] input_R1_AB,
  input  logic            input_R0_C_Ack,
  input  logic            input_R1_C_Ack,
  output logic            output_R0_AB_Ack,
  output logic            output_R1_AB_Ack,
  output logic            output_R0_Stable,
  output logic            output_R1_Stable,
  output logic [C_W-1:0]  output_R0_C,
  output logic [C_W-1:0]  output_R1_C,
  output logic            output_M_Stable,
  output logic [AB_W-1:0] output_M_AB,
  output logic            output_M_C_Ack,
  input  logic            input_M_AB_Ack,
  input  logic            input_M_Stable,
  input  logic [C_W-1:0]  input_M_C,
  input  logic            input_M_Free,
  output logic            output_Grant,
  output logic            output_Busy,
  output logic            output_Timeout
);

  state_t          r_state;
  logic            r_ptr;
  logic            r_grant;
  logic [AB_W-1:0] r_ab;
  logic [C_W-1:0]  r_c [2];
  logic [1:0]      r_ab_ack;
  logic [1:0]      r_stable;
  logic            r_m_stable;
  logic            r_m_c_ack;

  logic            w_req_any;
  logic            w_pick;
  logic            w_rg_c_ack;
  logic            w_expire;

  assign w_req_any  = input_R0_Stable | input_R1_Stable;
  assign w_pick     = arb_pick(input_R0_Stable, input_R1_Stable, r_ptr);
  assign w_rg_c_ack = r_grant ? input_R1_C_Ack : input_R0_C_Ack;

`ifdef AXA_ARB_TIMEOUT_EN
  logic w_fire;
  logic r_timeout;

  axa_arb_watchdog u_wdog (
    .i_clk   (input_Clk),
    .i_rst_n (input_Reset),
    .i_state (r_state),
    .o_fire  (w_fire)
  );

  // A genuine handshake on the limit edge wins over the watchdog.
  assign w_expire = w_fire && !((r_state == ST_ISSUE && input_M_AB_Ack) ||
                                (r_state == ST_WAIT  && input_M_Stable));

  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) r_timeout <= 1'b0;
    else              r_timeout <= w_expire;
  end

  assign output_Timeout = r_timeout;
`else
  assign w_expire       = 1'b0;
  assign output_Timeout = 1'b0;
`endif

  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_grant    <= 1'b0;
      r_ab       <= '0;
      r_c[0]     <= '0;
      r_c[1]     <= '0;
      r_ab_ack   <= '0;
      r_stable   <= '0;
      r_m_stable <= 1'b0;
      r_m_c_ack  <= 1'b0;
    end else begin
      r_ab_ack  <= '0;
      r_m_c_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (input_M_Free && w_req_any) begin
            r_grant    <= w_pick;
            r_ab       <= w_pick ? input_R1_AB : input_R0_AB;
            r_m_stable <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (input_M_AB_Ack || w_expire) begin
            r_ab_ack[r_grant] <= 1'b1;
            if (input_M_AB_Ack) begin
              r_state <= ST_WAIT;
            end else begin
              r_m_stable        <= 1'b0;
              r_c[r_grant]      <= '0;
              r_stable[r_grant] <= 1'b1;
              r_state           <= ST_DELIVER;
            end
          end
        end
        ST_WAIT: begin
          // A watchdog exit delivers an all-zero result and no M_C_Ack.
          if (input_M_Stable || w_expire) begin
            r_m_stable        <= 1'b0;
            r_m_c_ack         <= input_M_Stable;
            r_c[r_grant]      <= input_M_Stable ? input_M_C : '0;
            r_stable[r_grant] <= 1'b1;
            r_state           <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (w_rg_c_ack) begin
            r_stable[r_grant] <= 1'b0;
            r_ptr             <= ~r_grant;
            r_state           <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign output_R0_AB_Ack = r_ab_ack[0];
  assign output_R1_AB_Ack = r_ab_ack[1];
  assign output_R0_Stable = r_stable[0];
  assign output_R1_Stable = r_stable[1];
  assign output_R0_C      = r_c[0];
  assign output_R1_C      = r_c[1];
  assign output_M_Stable  = r_m_stable;
  assign output_M_AB      = r_ab;
  assign output_M_C_Ack   = r_m_c_ack;
  assign output_Grant     = r_grant;
  assign output_Busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axa_mult_arbiter.sv
// Directed bench for axa_mult_arbiter with a 5-cycle behavioural 2x2 float multiplier.
module tb_axa_mult_arbiter;

  localparam logic [255:0] AB1 = {32'h40400000, 32'h40C00000, 32'h40800000, 32'h40A00000,
                                  32'h40400000, 32'h40C00000, 32'h40800000, 32'h40A00000};
  localparam logic [255:0] AB2 = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
  localparam logic [255:0] AB3 = {32'h40000000, 32'h00000000, 32'h00000000, 32'h40000000,
                                  32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [127:0] C1  = {32'h42040000, 32'h42400000, 32'h42000000, 32'h42440000};
  localparam logic [127:0] C2  = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [127:0] C3  = {32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         r0_stb, r1_stb, r0_cack, r1_cack;
  logic [255:0] r0_ab, r1_ab;
  logic         r0_abk, r1_abk, r0_vld, r1_vld;
  logic [127:0] r0_c, r1_c;
  logic         m_stb, m_cack;
  logic [255:0] m_ab;
  logic         m_abk = 1'b0;
  logic         m_vld = 1'b0;
  logic [127:0] m_c = '0;
  logic         m_free;
  logic         grant, busy, tmo;

  int           n_chk = 0;
  int           n_err = 0;
  int           mstate = 0;
  int           mcnt = 0;
  logic [127:0] m_res = '0;
  bit           withhold = 1'b0;
  bit           free_en = 1'b1;
  int           cnt_abk0 = 0;
  int           cnt_abk1 = 0;
  int           cnt_mcack = 0;
  bit           prev_busy = 1'b0;
  int           glog[$];
  int           cyc;
  logic [255:0] gv;

  axa_mult_arbiter dut (
    .input_Clk        (clk),
    .input_Reset      (rst_n),
    .input_R0_Stable  (r0_stb),
    .input_R1_Stable  (r1_stb),
    .input_R0_AB      (r0_ab),
    .input_R1_AB      (r1_ab),
    .input_R0_C_Ack   (r0_cack),
    .input_R1_C_Ack   (r1_cack),
    .output_R0_AB_Ack (r0_abk),
    .output_R1_AB_Ack (r1_abk),
    .output_R0_Stable (r0_vld),
    .output_R1_Stable (r1_vld),
    .output_R0_C      (r0_c),
    .output_R1_C      (r1_c),
    .output_M_Stable  (m_stb),
    .output_M_AB      (m_ab),
    .output_M_C_Ack   (m_cack),
    .input_M_AB_Ack   (m_abk),
    .input_M_Stable   (m_vld),
    .input_M_C        (m_c),
    .input_M_Free     (m_free),
    .output_Grant     (grant),
    .output_Busy      (busy),
    .output_Timeout   (tmo)
  );

  always #5 clk = ~clk;

  assign m_free = free_en && (mstate == 0);

  function automatic real sp2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'd0;
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [127:0] mat_mul(input logic [255:0] ab);
    real a11, a12, a21, a22, b11, b12, b21, b22;
    a11 = sp2r(ab[255:224]); a12 = sp2r(ab[223:192]);
    a21 = sp2r(ab[191:160]); a22 = sp2r(ab[159:128]);
    b11 = sp2r(ab[127:96]);  b12 = sp2r(ab[95:64]);
    b21 = sp2r(ab[63:32]);   b22 = sp2r(ab[31:0]);
    return {r2sp(a11 * b11 + a12 * b21), r2sp(a11 * b12 + a12 * b22),
            r2sp(a21 * b11 + a22 * b21), r2sp(a21 * b12 + a22 * b22)};
  endfunction

  // Multiplier model plus pulse/grant monitor, all on the inactive edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mstate = 0;
      mcnt   = 0;
      m_abk  = 1'b0;
      m_vld  = 1'b0;
      m_c    = '0;
    end else begin
      case (mstate)
        0: if (m_stb) begin
          m_abk  = 1'b1;
          m_res  = mat_mul(m_ab);
          mcnt   = 5;
          mstate = 1;
        end
        1: begin
          m_abk = 1'b0;
          if (!withhold) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
              m_vld  = 1'b1;
              m_c    = m_res;
              mstate = 2;
            end
          end
        end
        default: if (m_cack) begin
          m_vld  = 1'b0;
          mstate = 0;
        end
      endcase
    end
    if (r0_abk) cnt_abk0++;
    if (r1_abk) cnt_abk1++;
    if (m_cack) cnt_mcack++;
    if (busy && !prev_busy) glog.push_back(int'(grant));
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return r0_vld;
      1:       return r1_vld;
      2:       return r0_abk;
      3:       return r1_abk;
      default: return tmo;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (sig(sel)) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic ack_c(input int n);
    if (n == 0) r0_cack = 1'b1;
    else        r1_cack = 1'b1;
    @(negedge clk);
    r0_cack = 1'b0;
    r1_cack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    r0_stb   = 1'b0;
    r1_stb   = 1'b0;
    r0_cack  = 1'b0;
    r1_cack  = 1'b0;
    withhold = 1'b0;
    free_en  = 1'b1;
    repeat (2) @(negedge clk);
    cnt_abk0  = 0;
    cnt_abk1  = 0;
    cnt_mcack = 0;
    glog.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    r0_stb = 1'b0; r1_stb = 1'b0; r0_cack = 1'b0; r1_cack = 1'b0;
    r0_ab = '0; r1_ab = '0;
    do_reset();

    chk("rst_ctl", 256'({busy, grant, m_stb, m_cack, tmo, r0_abk, r1_abk, r0_vld, r1_vld}), '0);
    chk("rst_mab", m_ab, '0);
    chk("rst_c", {r0_c, r1_c}, '0);

    // R0 alone
    r0_ab = AB1; r0_stb = 1'b1;
    wait_sig(2, 10, cyc);
    chk("s1_abk_lat", 256'(cyc), 256'(2));
    chk("s1_grant", 256'(grant), '0);
    chk("s1_mab", m_ab, AB1);
    chk("s1_mstb_wait", 256'(m_stb), 256'(1));
    r0_stb = 1'b0;
    wait_sig(0, 20, cyc);
    chk("s1_c_lat", 256'(cyc), 256'(5));
    chk("s1_r0c", 256'(r0_c), 256'(C1));
    chk("s1_r1_quiet", 256'({r1_vld, r1_abk, r1_c}), '0);
    chk("s1_mstb_drop", 256'(m_stb), '0);
    ack_c(0);
    chk("s1_pulses", 256'({cnt_abk0[7:0], cnt_mcack[7:0]}), 256'(16'h0101));
    chk("s1_idle", 256'({busy, r0_vld, tmo}), '0);
    chk("s1_r0c_hold", 256'(r0_c), 256'(C1));

    // simultaneous requests, round robin
    do_reset();
    r0_ab = AB1; r1_ab = AB2; r0_stb = 1'b1; r1_stb = 1'b1;
    wait_sig(2, 10, cyc);
    chk("s2_r0_first", 256'(cyc), 256'(2));
    r0_stb = 1'b0;
    wait_sig(0, 20, cyc);
    chk("s2_r0c", 256'(r0_c), 256'(C1));
    chk("s2_r1_waiting", 256'({r1_vld, r1_c}), '0);
    ack_c(0);
    wait_sig(3, 10, cyc);
    chk("s2_r1_abk_lat", 256'(cyc), 256'(2));
    chk("s2_r1_grant", 256'(grant), 256'(1));
    r1_stb = 1'b0;
    wait_sig(1, 20, cyc);
    chk("s2_r1c", 256'(r1_c), 256'(C2));
    chk("s2_r0_hold", 256'({r0_vld, r0_abk, r0_c}), 256'(C1));
    ack_c(1);
    r0_stb = 1'b1; r1_stb = 1'b1;
    wait_sig(2, 10, cyc);
    chk("s2_rr_r0_again", 256'(cyc), 256'(2));
    chk("s2_abk1_cnt", 256'(cnt_abk1), 256'(1));
    gv = '0;
    foreach (glog[i]) gv = (gv << 4) | 256'(glog[i]);
    chk("s2_grant_cnt", 256'(glog.size()), 256'(3));
    chk("s2_grant_seq", gv, 256'(12'h010));

    // R1 withdraws after being granted
    do_reset();
    r1_ab = AB3; r1_stb = 1'b1;
    @(negedge clk);
    chk("s3_grant", 256'({busy, grant}), 256'(2'b11));
    r1_stb = 1'b0;
    wait_sig(1, 20, cyc);
    chk("s3_lat", 256'(cyc), 256'(6));
    chk("s3_r1c", 256'(r1_c), 256'(C3));
    chk("s3_r0_quiet", 256'({r0_vld, r0_c}), '0);
    ack_c(1);
    chk("s3_idle", 256'({busy, r1_vld, cnt_abk1[7:0]}), 256'(10'h001));

    // reset while waiting on the multiplier
    cnt_mcack = 0;
    r0_ab = AB1; r0_stb = 1'b1;
    wait_sig(2, 10, cyc);
    r0_stb = 1'b0;
    @(negedge clk);
    chk("s4_in_wait", 256'({busy, m_stb}), 256'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("s4_rst_ctl", 256'({busy, grant, m_stb, m_cack, tmo, r0_abk, r1_abk, r0_vld, r1_vld}), '0);
    chk("s4_rst_mab", m_ab, '0);
    chk("s4_rst_c", {r0_c, r1_c}, '0);
    repeat (8) @(negedge clk);
    chk("s4_no_mcack", 256'(cnt_mcack), '0);
    rst_n = 1'b1;
    r0_stb = 1'b1;
    wait_sig(2, 10, cyc);
    chk("s4_resume_abk", 256'(cyc), 256'(2));
    r0_stb = 1'b0;
    wait_sig(0, 20, cyc);
    chk("s4_resume_c", 256'(r0_c), 256'(C1));
    ack_c(0);
    chk("s4_mcack_cnt", 256'(cnt_mcack), 256'(1));

    // multiplier not free
    free_en = 1'b0;
    r0_ab = AB2; r0_stb = 1'b1;
    repeat (6) @(negedge clk);
    chk("s5_no_grant", 256'({busy, m_stb, r0_abk}), '0);
    free_en = 1'b1;
    @(negedge clk);
    chk("s5_issue", 256'({busy, m_stb}), 256'(2'b11));
    wait_sig(2, 10, cyc);
    chk("s5_abk_lat", 256'(cyc), 256'(1));
    r0_stb = 1'b0;
    wait_sig(0, 20, cyc);
    chk("s5_r0c", 256'(r0_c), 256'(C2));
    ack_c(0);

    // multiplier never answers
    withhold = 1'b1;
    r0_ab = AB1; r0_stb = 1'b1;
    wait_sig(2, 10, cyc);
    r0_stb = 1'b0;
`ifdef AXA_ARB_TIMEOUT_EN
    wait_sig(4, 300, cyc);
    chk("s6_to_lat", 256'(cyc), 256'(256));
    chk("s6_deliver", 256'({r0_vld, m_stb, m_cack}), 256'(3'b100));
    chk("s6_r0c_zero", 256'(r0_c), '0);
    @(negedge clk);
    chk("s6_to_pulse", 256'(tmo), '0);
    ack_c(0);
    chk("s6_idle", 256'({busy, r0_vld}), '0);
`else
    repeat (300) @(negedge clk);
    chk("s6_unbounded", 256'({busy, m_stb, r0_vld, tmo}), 256'(4'b1100));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axa_mult_arbiter.md
AXA_MULT_ARBITER -- requirements
Module: axa_mult_arbiter

Interface
REQ-001 SHALL have ports, in this order:
- input_Clk  in  1  single clock, rising edge.
- input_Reset  in  1  asynchronous, active-low reset.
- input_Rn_Stable  in  1  requester n (n=0,1) operands valid.
- input_Rn_AB  in  256  requester n operands, packed {A11,A12,A21,A22,B11,B12,B21,B22}, IEEE-754 single.
- input_Rn_C_Ack  in  1  requester n has consumed its result.
- output_Rn_AB_Ack  out  1  one-cycle pulse: requester n operands accepted by the multiplier.
- output_Rn_Stable  out  1  requester n result valid.
- output_Rn_C  out  128  requester n result, packed {C11,C12,C21,C22}.
- output_M_Stable  out  1  operands valid toward the shared 2x2 multiplier.
- output_M_AB  out  256  latched operands toward the multiplier.
- output_M_C_Ack  out  1  one-cycle pulse: result taken from the multiplier.
- input_M_AB_Ack  in  1  multiplier operand acknowledge.
- input_M_Stable  in  1  multiplier result valid.
- input_M_C  in  128  multiplier result.
- input_M_Free  in  1  multiplier idle.
- output_Grant  out  1  index of the requester currently owning the multiplier.
- output_Busy  out  1  high in every state except IDLE.
- output_Timeout  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-002 SHALL implement FSM states IDLE, ISSUE, WAIT, DELIVER.
REQ-003 IDLE: when input_M_Free=1 and any input_Rn_Stable=1, grant, latch input_Rg_AB into the operand register, set output_Grant=g and go to ISSUE on the next edge; otherwise remain in IDLE.
REQ-004 Arbitration SHALL be round-robin: the pointer starts at 0; a single request wins immediately; on simultaneous requests the pointer selects the winner; the pointer moves to the other requester when DELIVER completes.
REQ-005 ISSUE: output_M_Stable=1 and output_M_AB=latched operands; when input_M_AB_Ack=1, pulse output_Rg_AB_Ack for one cycle and go to WAIT.
REQ-006 WAIT: hold output_M_Stable=1; when input_M_Stable=1, latch input_M_C, pulse output_M_C_Ack for one cycle, drop output_M_Stable and go to DELIVER.
REQ-007 DELIVER: output_Rg_Stable=1 and output_Rg_C=latched result; on input_Rg_C_Ack=1, drop output_Rg_Stable, advance the pointer and return to IDLE on the same edge.
REQ-008 A grant SHALL be committed: deassertion of input_Rg_Stable after the grant SHALL NOT abort the transaction.
REQ-009 The non-granted requester's outputs SHALL stay 0, and its result bus SHALL hold its last delivered value.
REQ-010 Minimum latency SHALL be 1 cycle request-to-ISSUE, plus multiplier latency, plus 1 cycle to DELIVER.
REQ-011 A request arriving while output_Busy=1 SHALL wait, with no loss, until IDLE.
REQ-012 In IDLE with input_M_Free=0, no grant SHALL be issued.
REQ-013 Data SHALL pass through bit-exact; the block SHALL perform no arithmetic.

Reset
REQ-014 input_Reset=0 SHALL asynchronously force IDLE, pointer=0, output_Grant=0, and all outputs and latched operand/result registers to 0.
REQ-015 A reset during ISSUE, WAIT or DELIVER SHALL abandon the transaction with no acknowledge pulses; operation resumes from IDLE on the first edge after release.

Configuration
REQ-016 With macro AXA_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in ISSUE or WAIT, clearing on every state change.
- At count 256 it SHALL pulse output_Timeout, drop output_M_Stable and go to DELIVER with output_Rg_C=0.
- If the timeout fires in ISSUE, it SHALL also pulse output_Rg_AB_Ack.
REQ-017 Without AXA_ARB_TIMEOUT_EN, output_Timeout SHALL be tied to 0, no counter logic SHALL exist, and WAIT SHALL be unbounded.

Structure
REQ-018 Package axa_arb_pkg SHALL hold: the state encoding, AB_W=256, C_W=128, WORD_W=32, TIMEOUT_CYCLES=256.
REQ-019 The watchdog SHALL be the sub-module axa_arb_watchdog, instantiated only under AXA_ARB_TIMEOUT_EN; all other logic stays in one module.

Verification
REQ-020 The bench SHALL drive a behavioural 2x2 float multiplier model with 5-cycle latency and SHALL cover:
- R0 only, A=B={3,6,4,5} -> R0_AB_Ack pulse, then R0_C={0x42040000,0x42400000,0x42000000,0x42440000} (33,48,32,49); Grant=0.
- R0 and R1 request in the same cycle after reset -> R0 served first, R1 second, Grant sequence 0,1; a following simultaneous pair -> R0 served again (pointer returned to 0 after the R1 transaction).
- R1 drops Stable one cycle after grant -> transaction completes; R1_Stable asserts with the correct C.
- Reset pulled low in WAIT -> all outputs 0 within the same cycle; no M_C_Ack pulse; a new R0 request after release is served normally.
- Model withholds M_Stable forever with AXA_ARB_TIMEOUT_EN -> Timeout pulse 256 cycles after WAIT entry; R0_C=0; FSM returns to IDLE after C_Ack.
- input_M_Free=0 while R0 requests -> no grant until M_Free=1, then ISSUE on the next edge.
